acc_unit_16: RTL and testbench
==============================

ACC_UNIT_16 -- requirements
Module: acc_unit_16

Interface
REQ-001 SHALL have parameter: STICKY_OV, 0, 1 = overflow flag sticky until CLR/LOAD; 0 = per-operation.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: in_op  input  2  00 CLR, 01 LOAD, 10 ADD, 11 SUB.
REQ-007 SHALL have port: in_data  input  16  operand.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: acc  output  16  accumulator value.
REQ-011 SHALL have port: flags  output  5  {zero, cout, overflow, parity, sign}, bit 0 = sign.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in RESP.
REQ-013 SHALL, in IDLE, capture in_op/in_data and enter EXEC on in_valid & in_ready; otherwise stay in IDLE.
REQ-014 SHALL, in EXEC, update acc and flags in one cycle and enter RESP; out_valid rises two edges after the accepting edge.
REQ-015 SHALL hold RESP, with acc/flags stable, until out_ready = 1; it SHALL return to IDLE on that edge; in_valid ignored outside IDLE.
REQ-016 SHALL compute CLR: acc = 0; LOAD: acc = operand; ADD: acc + operand, cin 0; SUB: acc + ~operand, cin 1; 16-bit wrap, two's complement.
REQ-017 SHALL set sign = acc[15], parity = XNOR-reduction of acc (1 = even ones), zero = (acc == 0), all from the stored acc value.
REQ-018 SHALL set cout = raw adder carry-out (for SUB, 1 = no borrow), overflow = operands to the adder share sign and the raw sum differs from them; CLR/LOAD SHALL clear cout and overflow.
REQ-019 SHALL, with STICKY_OV = 1, OR new overflow into the held flag on ADD/SUB; only CLR, LOAD or reset clear it.

Reset
REQ-020 SHALL, on rst high, immediately force state IDLE, acc = 0x0000, flags = 5'b00000, out_valid = 0; in_ready = 1 after release.
REQ-021 SHALL abandon any operation in EXEC/RESP on reset; no result is presented afterwards.

Configuration
REQ-022 SHALL, with ACC_SAT_EN defined, clamp ADD/SUB on overflow to 0x7FFF (positive) or 0x8000 (negative); overflow still = 1, sign/parity/zero follow the clamped value.
REQ-023 SHALL, without ACC_SAT_EN, wrap modulo 2^16 with no saturation logic present.

Structure
REQ-024 SHALL place op encodings (OP_CLR/OP_LOAD/OP_ADD/OP_SUB), FSM state encodings and flag bit indices in a shared package acc_pkg.
REQ-025 SHALL instantiate exactly one hybrid_adder_16 as datapath sub-module; flags computed locally from its sum/cout.

Verification
REQ-026 SHALL cover: rst asserted while in RESP -> out_valid 0 same cycle, acc 0x0000, flags 00000, in_ready 1 after release.
REQ-027 SHALL cover: LOAD 0x7FFF, ADD 0x0001 -> acc 0x8000, overflow 1, sign 1, cout 0 (ACC_SAT_EN: acc 0x7FFF, sign 0, overflow 1).
REQ-028 SHALL cover: LOAD 0xFFFF, ADD 0x0001 -> acc 0x0000, cout 1, zero 1, overflow 0, parity 1.
REQ-029 SHALL cover: LOAD 0x0005, SUB 0x0007 -> acc 0xFFFE, sign 1, cout 0, parity 0, overflow 0.
REQ-030 SHALL cover: out_ready low 5 cycles with in_valid high -> out_valid, acc, flags stable, in_ready 0, no request accepted; release -> IDLE next edge.
REQ-031 SHALL cover: STICKY_OV = 1, ADD overflow then ADD 0x0000 -> overflow remains 1; CLR -> overflow 0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared encodings for the 16-bit accumulator unit: operations, FSM states
// and flag bit positions.
package acc_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int FLAG_SIGN   = 0;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_OV     = 2;
    localparam int FLAG_COUT   = 3;
    localparam int FLAG_ZERO   = 4;

    function automatic logic [4:0] pack_flags(input logic zero, input logic cout,
                                              input logic ov, input logic parity,
                                              input logic sign);
        logic [4:0] f;
        f              = '0;
        f[FLAG_ZERO]   = zero;
        f[FLAG_COUT]   = cout;
        f[FLAG_OV]     = ov;
        f[FLAG_PARITY] = parity;
        f[FLAG_SIGN]   = sign;
        return f;
    endfunction

endpackage

// File: rtl/hybrid_adder_16.sv
// 16-bit adder built from four 4-bit carry-lookahead groups whose group
// carries ripple from one group to the next.
module hybrid_adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0] gc;

    assign gc[0] = cin;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_grp
            logic [3:0] p;
            logic [3:0] gn;
            logic [4:0] c;

            assign p  = a[4*g +: 4] ^ b[4*g +: 4];
            assign gn = a[4*g +: 4] & b[4*g +: 4];

            // Lookahead carries inside the group, all derived from the group carry-in
            assign c[0] = gc[g];
            assign c[1] = gn[0] | (p[0] & c[0]);
            assign c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                        | (p[3] & p[2] & p[1] & gn[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum[4*g +: 4] = p ^ c[3:0];
            assign gc[g+1]       = c[4];
        end
    endgenerate

    assign cout = gc[4];

endmodule

// File: rtl/acc_unit_16.sv
// Handshaked 16-bit accumulator (CLR/LOAD/ADD/SUB) with status flags.
// Define ACC_SAT_EN to saturate ADD/SUB results on signed overflow.
module acc_unit_16
    import acc_pkg::*;
#(
    parameter bit STICKY_OV = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] acc,
    output logic [4:0]  flags
);

    state_e      state_q;
    state_e      state_d;
    op_e         op_q;
    logic [15:0] data_q;

    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        ov_raw;
    logic        is_arith;
    logic [15:0] acc_d;
    logic        cout_d;
    logic        ov_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_CLR;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            op_q   <= op_e'(in_op);
            data_q <= in_data;
        end
    end

    // SUB is acc + ~operand + 1, so cout = 1 means no borrow occurred
    assign add_b   = (op_q == OP_SUB) ? ~data_q : data_q;
    assign add_cin = (op_q == OP_SUB);

    hybrid_adder_16 u_adder (
        .a    (acc),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign ov_raw   = (acc[15] == add_b[15]) && (add_sum[15] != acc[15]);

    always_comb begin
        acc_d  = '0;
        cout_d = 1'b0;
        ov_d   = 1'b0;
        case (op_q)
            OP_CLR:  acc_d = '0;
            OP_LOAD: acc_d = data_q;
            default: begin
                acc_d  = add_sum;
                cout_d = add_cout;
                ov_d   = ov_raw;
`ifdef ACC_SAT_EN
                // On overflow both adder operands share acc's sign, which picks the rail
                if (ov_raw) begin
                    acc_d = acc[15] ? 16'h8000 : 16'h7FFF;
                end
`endif
            end
        endcase
        if (STICKY_OV && is_arith) begin
            ov_d = ov_d | flags[FLAG_OV];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            flags <= '0;
        end else if (state_q == ST_EXEC) begin
            acc   <= acc_d;
            flags <= pack_flags(acc_d == 16'h0000, cout_d, ov_d, ~^acc_d, acc_d[15]);
        end
    end

endmodule

// File: tb/tb_acc_unit_16.sv
// Scoreboard bench for acc_unit_16: runs a per-operation and a sticky-overflow
// instance side by side against a behavioural model of the accumulator.
module tb_acc_unit_16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] acc;
    logic [4:0]  flags;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [15:0] acc_s;
    logic [4:0]  flags_s;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] acc;
        logic [4:0]  flags;
        logic [4:0]  flags_s;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] m_acc;
    logic        m_ov_s;

    acc_unit_16 #(.STICKY_OV(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .flags     (flags)
    );

    acc_unit_16 #(.STICKY_OV(1'b1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .acc       (acc_s),
        .flags     (flags_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    // Independent 17-bit reference of one operation, pushed onto the scoreboard
    task automatic modelStep(input logic [1:0] op, input logic [15:0] data);
        logic [16:0] s;
        logic [15:0] b;
        logic [15:0] r;
        logic        co;
        logic        ov;
        exp_t        e;
        b  = (op == 2'b11) ? ~data : data;
        s  = {1'b0, m_acc} + {1'b0, b} + {16'b0, (op == 2'b11)};
        co = 1'b0;
        ov = 1'b0;
        r  = 16'h0000;
        if (op == 2'b01) begin
            r = data;
        end else if (op[1]) begin
            r  = s[15:0];
            co = s[16];
            ov = (m_acc[15] == b[15]) && (s[15] != m_acc[15]);
`ifdef ACC_SAT_EN
            if (ov) r = m_acc[15] ? 16'h8000 : 16'h7FFF;
`endif
        end
        m_ov_s    = op[1] ? (m_ov_s | ov) : 1'b0;
        m_acc     = r;
        e.acc     = r;
        e.flags   = {(r == 16'h0000), co, ov, ~^r, r[15]};
        e.flags_s = {(r == 16'h0000), co, m_ov_s, ~^r, r[15]};
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWait", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        modelStep(op, data);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("latencyExec", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("latencyResp", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic collectResult();
        exp_t e;
        checkOutput("sbDepth", sbq.size(), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("outValid", {31'b0, out_valid}, 32'd1);
            checkOutput("outValidS", {31'b0, out_valid_s}, 32'd1);
            checkOutput("acc", {16'b0, acc}, {16'b0, e.acc});
            checkOutput("flags", {27'b0, flags}, {27'b0, e.flags});
            checkOutput("accS", {16'b0, acc_s}, {16'b0, e.acc});
            checkOutput("flagsS", {27'b0, flags_s}, {27'b0, e.flags_s});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("backToIdle", {31'b0, in_ready}, 32'd1);
        checkOutput("respDropped", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [15:0] data);
        applyStimulus(op, data);
        collectResult();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        m_acc     = 16'h0000;
        m_ov_s    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstAcc", {16'b0, acc}, 32'd0);
        checkOutput("rstFlags", {27'b0, flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);

        runOp(2'b00, 16'h1234);

        runOp(2'b01, 16'h7FFF);
        runOp(2'b10, 16'h0001);
        runOp(2'b10, 16'h0000);
        runOp(2'b00, 16'h0000);

        runOp(2'b01, 16'hFFFF);
        runOp(2'b10, 16'h0001);

        runOp(2'b01, 16'h0005);
        runOp(2'b11, 16'h0007);

        runOp(2'b01, 16'h8000);
        runOp(2'b11, 16'h0001);

        // Hold a response while new requests are offered and must be ignored
        applyStimulus(2'b10, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_op    = 2'b01;
            in_data  = 16'hBEEF;
            @(negedge clk);
            checkOutput("holdValid", {31'b0, out_valid}, 32'd1);
            checkOutput("holdReady", {31'b0, in_ready}, 32'd0);
            checkOutput("holdAcc", {16'b0, acc}, {16'b0, sbq[0].acc});
            checkOutput("holdFlags", {27'b0, flags}, {27'b0, sbq[0].flags});
        end
        in_valid = 1'b0;
        collectResult();
        runOp(2'b10, 16'h0000);

        // Reset while a result is being presented
        applyStimulus(2'b01, 16'h5A5A);
        rst = 1'b1;
        #1;
        checkOutput("rstRespValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstRespAcc", {16'b0, acc}, 32'd0);
        checkOutput("rstRespFlags", {27'b0, flags}, 32'd0);
        checkOutput("rstRespFlagsS", {27'b0, flags_s}, 32'd0);
        sbq.delete();
        m_acc  = 16'h0000;
        m_ov_s = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRespReady", {31'b0, in_ready}, 32'd1);
        checkOutput("rstRespNoOut", {31'b0, out_valid}, 32'd0);
        runOp(2'b10, 16'h0003);

        for (int i = 0; i < 24; i++) begin
            runOp(2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
